// File: rtl/door_lock_pkg.sv
// ============================================================================
// Module      : door_lock_pkg
// Description : Shared state encoding, keypad codes and 7-segment patterns
//               for the keypad door lock. DOOR_LOCK_LOCKOUT_EN adds LOCKOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package door_lock_pkg;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_CLEAR = 4'd15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
`ifdef DOOR_LOCK_LOCKOUT_EN
        ERROR   = 3'd3,
        LOCKOUT = 3'd4
`else
        ERROR   = 3'd3
`endif
    } state_t;

    localparam logic [6:0] SEG_IDLE    = 7'h40;
    localparam logic [6:0] SEG_CNT1    = 7'h06;
    localparam logic [6:0] SEG_CNT2    = 7'h5B;
    localparam logic [6:0] SEG_CNT3    = 7'h4F;
    localparam logic [6:0] SEG_OPEN    = 7'h3F;
    localparam logic [6:0] SEG_ERROR   = 7'h79;
    localparam logic [6:0] SEG_LOCKOUT = 7'h38;

    // Digit idx 0 is the first one entered and lives in the top nibble.
    function automatic logic [3:0] pw_nibble(input logic [15:0] pw, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = pw[15:12];
            2'd1:    nib = pw[11:8];
            2'd2:    nib = pw[7:4];
            default: nib = pw[3:0];
        endcase
        return nib;
    endfunction

endpackage

`default_nettype wire

// File: rtl/door_lock_seg7.sv
// ============================================================================
// Module      : door_lock_seg7
// Description : Combinational state/count to 7-segment pattern map. Digits are
//               never echoed; only progress through the code is shown.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module door_lock_seg7
    import door_lock_pkg::*;
(
    input  state_t     state,
    input  logic [1:0] count,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_IDLE;
        case (state)
            IDLE:    seg = SEG_IDLE;
            ENTRY: begin
                case (count)
                    2'd1:    seg = SEG_CNT1;
                    2'd2:    seg = SEG_CNT2;
                    2'd3:    seg = SEG_CNT3;
                    default: seg = SEG_IDLE;
                endcase
            end
            OPEN:    seg = SEG_OPEN;
            ERROR:   seg = SEG_ERROR;
`ifdef DOOR_LOCK_LOCKOUT_EN
            LOCKOUT: seg = SEG_LOCKOUT;
`endif
            default: seg = SEG_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/door_lock.sv
// ============================================================================
// Module      : door_lock
// Description : Four-digit keypad door lock with error buzzer, optional
//               auto-relock, and lockout when DOOR_LOCK_LOCKOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module door_lock
    import door_lock_pkg::*;
#(
    parameter logic [15:0] PASSWORD      = 16'h1234,
    parameter int          ERR_CYCLES    = 8,
`ifdef DOOR_LOCK_LOCKOUT_EN
    parameter int          RELOCK_CYCLES = 0,
    parameter int          MAX_FAILS     = 3
`else
    parameter int          RELOCK_CYCLES = 0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad,
    output logic [6:0] seg,
    output logic       buzzer,
    output logic       lock
);

    localparam int ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam int REL_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam int TMR_W = (ERR_W > REL_W) ? ERR_W : REL_W;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_count, w_count_nxt;
    logic               r_bad, w_bad_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [3:0]         r_key_q;
    logic [6:0]         w_seg;
    logic               w_press, w_digit, w_clear, w_match;

`ifdef DOOR_LOCK_LOCKOUT_EN
    localparam int FAIL_W = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1;
    logic [FAIL_W-1:0]  r_fails, w_fails_nxt;
`endif

    // A press is a new nonzero code; a held key is seen only once.
    assign w_press = (keypad != KEY_NONE) && (keypad != r_key_q);
    assign w_digit = w_press && (keypad != KEY_CLEAR);
    assign w_clear = w_press && (keypad == KEY_CLEAR);
    assign w_match = (keypad == pw_nibble(PASSWORD, r_count));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_bad_nxt   = r_bad;
        w_timer_nxt = '0;
`ifdef DOOR_LOCK_LOCKOUT_EN
        w_fails_nxt = r_fails;
`endif
        case (r_state)
            IDLE: begin
                if (w_digit) begin
                    w_state_nxt = ENTRY;
                    w_count_nxt = 2'd1;
                    w_bad_nxt   = !w_match;
                end
            end
            ENTRY: begin
                if (w_clear) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = 2'd0;
                    w_bad_nxt   = 1'b0;
                end else if (w_digit) begin
                    if (r_count == 2'd3) begin
                        w_count_nxt = 2'd0;
                        w_bad_nxt   = 1'b0;
                        if (!r_bad && w_match) begin
                            w_state_nxt = OPEN;
`ifdef DOOR_LOCK_LOCKOUT_EN
                            w_fails_nxt = '0;
`endif
                        end else begin
                            w_state_nxt = ERROR;
`ifdef DOOR_LOCK_LOCKOUT_EN
                            if (r_fails != FAIL_W'(MAX_FAILS))
                                w_fails_nxt = r_fails + 1'b1;
`endif
                        end
                    end else begin
                        w_count_nxt = r_count + 2'd1;
                        w_bad_nxt   = r_bad | !w_match;
                    end
                end
            end
            OPEN: begin
                if (w_clear || (RELOCK_CYCLES != 0 && r_timer == TMR_W'(RELOCK_CYCLES - 1)))
                    w_state_nxt = IDLE;
                else if (RELOCK_CYCLES != 0)
                    w_timer_nxt = r_timer + 1'b1;
            end
            ERROR: begin
                if (r_timer == TMR_W'(ERR_CYCLES - 1)) begin
`ifdef DOOR_LOCK_LOCKOUT_EN
                    w_state_nxt = (r_fails >= FAIL_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
`else
                    w_state_nxt = IDLE;
`endif
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
`ifdef DOOR_LOCK_LOCKOUT_EN
            LOCKOUT: w_state_nxt = LOCKOUT;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they change on the same edge.
    door_lock_seg7 u_seg7 (
        .state (w_state_nxt),
        .count (w_count_nxt),
        .seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= 2'd0;
            r_bad   <= 1'b0;
            r_timer <= '0;
            r_key_q <= KEY_NONE;
`ifdef DOOR_LOCK_LOCKOUT_EN
            r_fails <= '0;
`endif
            seg     <= SEG_IDLE;
            lock    <= 1'b1;
            buzzer  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_bad   <= w_bad_nxt;
            r_timer <= w_timer_nxt;
            r_key_q <= keypad;
`ifdef DOOR_LOCK_LOCKOUT_EN
            r_fails <= w_fails_nxt;
            buzzer  <= (w_state_nxt == ERROR) || (w_state_nxt == LOCKOUT);
`else
            buzzer  <= (w_state_nxt == ERROR);
`endif
            seg     <= w_seg;
            lock    <= (w_state_nxt != OPEN);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_door_lock.sv
// ============================================================================
// Module      : tb_door_lock
// Description : Directed self-checking bench for door_lock with default
//               parameters; lockout steps run when DOOR_LOCK_LOCKOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_door_lock;

    logic       clk;
    logic       rst;
    logic [3:0] keypad;
    logic [6:0] w_seg;
    logic       w_buzzer;
    logic       w_lock;

    int checks;
    int errors;

    door_lock dut (
        .clk    (clk),
        .rst    (rst),
        .keypad (keypad),
        .seg    (w_seg),
        .buzzer (w_buzzer),
        .lock   (w_lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] s, input logic l, input logic b);
        chk({tag, ".seg"},    {1'b0, w_seg},   {1'b0, s});
        chk({tag, ".lock"},   {7'd0, w_lock},  {7'd0, l});
        chk({tag, ".buzzer"}, {7'd0, w_buzzer}, {7'd0, b});
    endtask

    // Drive a key just after a rising edge, then look just after the next one.
    task automatic tick(input logic [3:0] k);
        keypad = k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        keypad = 4'd0;
        rst = 1'b0;
        #2;
        chk_out("reset", 7'h40, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        keypad = 4'd0;
        #1;
        do_reset();

        // correct code, showing entry progress
        tick(4'd1); chk_out("s1.k1", 7'h06, 1'b1, 1'b0);
        tick(4'd2); chk_out("s1.k2", 7'h5B, 1'b1, 1'b0);
        tick(4'd3); chk_out("s1.k3", 7'h4F, 1'b1, 1'b0);
        tick(4'd4); chk_out("s1.k4", 7'h3F, 1'b0, 1'b0);
        tick(4'd0); chk_out("s1.hold", 7'h3F, 1'b0, 1'b0);
        tick(4'd5); chk_out("s1.digit_ignored", 7'h3F, 1'b0, 1'b0);

        // relock, then a held key counts once
        tick(4'd15); chk_out("s4.relock", 7'h40, 1'b1, 1'b0);
        tick(4'd0);
        for (int i = 0; i < 5; i++) begin
            tick(4'd1); chk_out("s4.held", 7'h06, 1'b1, 1'b0);
        end
        tick(4'd0);  chk_out("s4.release", 7'h06, 1'b1, 1'b0);
        tick(4'd15); chk_out("s4.clear", 7'h40, 1'b1, 1'b0);
        tick(4'd0);

        // wrong code: buzzer for exactly 8 cycles, presses ignored meanwhile
        do_reset();
        tick(4'd3); tick(4'd5); tick(4'd1);
        tick(4'd6); chk_out("s2.err1", 7'h79, 1'b1, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            tick((i == 4) ? 4'd15 : ((i == 6) ? 4'd1 : 4'd0));
            chk_out("s2.err_hold", 7'h79, 1'b1, 1'b1);
        end
        tick(4'd0); chk_out("s2.idle", 7'h40, 1'b1, 1'b0);

        // CLEAR mid-entry restarts without penalty
        tick(4'd1);  chk_out("s3.k1", 7'h06, 1'b1, 1'b0);
        tick(4'd2);  chk_out("s3.k2", 7'h5B, 1'b1, 1'b0);
        tick(4'd15); chk_out("s3.clear", 7'h40, 1'b1, 1'b0);
        tick(4'd1); tick(4'd2); tick(4'd3);
        tick(4'd4);  chk_out("s3.open", 7'h3F, 1'b0, 1'b0);
        tick(4'd15); chk_out("s3.relock", 7'h40, 1'b1, 1'b0);
        tick(4'd0);

        // a single wrong middle digit does not abort entry but still fails
        tick(4'd1);
        tick(4'd9); chk_out("bad.k2", 7'h5B, 1'b1, 1'b0);
        tick(4'd3); chk_out("bad.k3", 7'h4F, 1'b1, 1'b0);
        tick(4'd4); chk_out("bad.k4", 7'h79, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(4'd0);
        chk_out("bad.idle", 7'h40, 1'b1, 1'b0);

        // reset mid-entry discards progress
        tick(4'd1); tick(4'd2); tick(4'd3);
        keypad = 4'd0;
        rst = 1'b0;
        #2;
        chk_out("s5.in_reset", 7'h40, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(4'd4); chk_out("s5.after", 7'h06, 1'b1, 1'b0);
        tick(4'd0);

`ifdef DOOR_LOCK_LOCKOUT_EN
        do_reset();
        for (int r = 0; r < 3; r++) begin
            tick(4'd3); tick(4'd5); tick(4'd1); tick(4'd6);
            for (int i = 0; i < 8; i++) tick(4'd0);
            if (r < 2) chk_out("s6.idle", 7'h40, 1'b1, 1'b0);
        end
        chk_out("s6.lockout", 7'h38, 1'b1, 1'b1);
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4); tick(4'd0);
        chk_out("s6.ignored", 7'h38, 1'b1, 1'b1);
        do_reset();
        tick(4'd0); chk_out("s6.cleared", 7'h40, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
